// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC vector sequencer and its operand FIFO.
package mac_seq_pkg;

    localparam int unsigned OP_W  = 16;
    localparam int unsigned ACC_W = 32;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StRun,
        StDrain,
        StHold
    } seq_state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            last;
    } operand_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous operand FIFO; no bypass, so a push is visible to pop one cycle later.
module mac_operand_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_vector_sequencer.sv
// Feeds buffered operand pairs into the external MAC one vector at a time and returns
// each dot product with its pair count, wrap flag and truncation flag.
module mac_vector_sequencer
    import mac_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned LEN_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic [OP_W-1:0]   mac_a,
    output logic [OP_W-1:0]   mac_b,
    output logic              mac_cin,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  mac_acc,
    input  logic              mac_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [LEN_W-1:0]  res_count,
    output logic              res_ovf,
    output logic              res_trunc
);

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    operand_t         fifo_wdata;
    operand_t         fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    seq_state_e       state_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_inc;
    logic             ovf_q;
    logic             trunc_q;
    logic             pair_on_q;
    logic             drain_q;
    logic             mac_clr_q;
    logic [OP_W-1:0]  mac_a_q;
    logic [OP_W-1:0]  mac_b_q;
    logic             res_valid_q;
    logic [ACC_W-1:0] res_data_q;
    logic [LEN_W-1:0] res_count_q;
    logic             res_ovf_q;
    logic             res_trunc_q;

    assign fifo_wdata = '{a: in_a, b: in_b, last: in_last};
    assign push       = in_valid && !fifo_full;
    assign pop        = (state_q == StRun) && !fifo_empty;
    assign count_inc  = count_q + 1'b1;

    mac_operand_fifo #(
        .WIDTH ($bits(operand_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StClear;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            trunc_q     <= 1'b0;
            pair_on_q   <= 1'b0;
            drain_q     <= 1'b0;
            mac_clr_q   <= 1'b1;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
            res_trunc_q <= 1'b0;
        end else begin
            mac_clr_q <= 1'b0;
            pair_on_q <= 1'b0;
            // pair_on_q marks a counted pair currently presented to the MAC adder.
            if (pair_on_q && mac_cout) begin
                ovf_q <= 1'b1;
            end
            unique case (state_q)
                StClear: begin
                    count_q <= '0;
                    ovf_q   <= 1'b0;
                    trunc_q <= 1'b0;
                    mac_a_q <= '0;
                    mac_b_q <= '0;
                    state_q <= StIdle;
                end
                StIdle: begin
                    mac_a_q <= '0;
                    mac_b_q <= '0;
                    if (!fifo_empty) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (pop) begin
                        mac_a_q   <= fifo_rdata.a;
                        mac_b_q   <= fifo_rdata.b;
                        pair_on_q <= 1'b1;
                        count_q   <= count_inc;
                        if (fifo_rdata.last || (count_inc == MAX_CNT)) begin
                            trunc_q <= !fifo_rdata.last;
                            drain_q <= 1'b0;
                            state_q <= StDrain;
                        end
                    end else begin
                        mac_a_q <= '0;
                        mac_b_q <= '0;
                    end
                end
                StDrain: begin
                    // First cycle lets the final pair land in the accumulator.
                    mac_a_q <= '0;
                    mac_b_q <= '0;
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        res_data_q  <= mac_acc;
                        res_count_q <= count_q;
                        res_ovf_q   <= ovf_q;
                        res_trunc_q <= trunc_q;
                        res_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        mac_clr_q   <= 1'b1;
                        state_q     <= StClear;
                    end
                end
                default: begin
                    mac_clr_q <= 1'b1;
                    state_q   <= StClear;
                end
            endcase
        end
    end

    assign in_ready  = !fifo_full;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_cin   = 1'b0;
    assign mac_clr   = mac_clr_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_count = res_count_q;
    assign res_ovf   = res_ovf_q;
    assign res_trunc = res_trunc_q;

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Scoreboard bench for mac_vector_sequencer with a behavioural MAC model attached.
module tb_mac_vector_sequencer;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned LEN_W   = 9;

    typedef struct {
        logic [31:0]      data;
        logic [LEN_W-1:0] cnt;
        logic             ovf;
        logic             trunc;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             in_last;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_cin;
    logic             mac_clr;
    logic [31:0]      mac_acc;
    logic             mac_cout;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [LEN_W-1:0] res_count;
    logic             res_ovf;
    logic             res_trunc;

    int   total = 0;
    int   bad = 0;
    int   n_results = 0;
    res_t exp_q[$];

    logic [31:0] m_sum = '0;
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;

    always #5 clk = ~clk;

    mac_vector_sequencer #(
        .DEPTH   (4),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_cin   (mac_cin),
        .mac_clr   (mac_clr),
        .mac_acc   (mac_acc),
        .mac_cout  (mac_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count),
        .res_ovf   (res_ovf),
        .res_trunc (res_trunc)
    );

    // Behavioural MAC: registered accumulator, async clear, combinational carry-out.
    logic [31:0] prod;
    logic [32:0] mac_sum;
    assign prod     = 32'(mac_a) * 32'(mac_b);
    assign mac_sum  = {1'b0, mac_acc} + {1'b0, prod} + 33'(mac_cin);
    assign mac_cout = mac_sum[32];

    always_ff @(posedge clk or posedge mac_clr) begin
        if (mac_clr) mac_acc <= '0;
        else         mac_acc <= mac_sum[31:0];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        logic [32:0] s;
        res_t r;
        s = {1'b0, m_sum} + {1'b0, 32'(a) * 32'(b)};
        m_sum = s[31:0];
        m_ovf = m_ovf | s[32];
        m_cnt++;
        if (last || m_cnt == int'(MAX_LEN)) begin
            r.data  = m_sum;
            r.cnt   = LEN_W'(m_cnt);
            r.ovf   = m_ovf;
            r.trunc = !last;
            exp_q.push_back(r);
            m_sum = '0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end
    endtask

    // Called in the posedge+1 phase; returns in the same phase after acceptance.
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        int g = 0;
        in_a = a;
        in_b = b;
        in_last = last;
        in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) check_eq("push_timeout", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        model_pair(a, b, last);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 64'(res_data), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check_eq("res_data", 64'(res_data), 64'(e.data));
                check_eq("res_count", 64'(res_count), 64'(e.cnt));
                check_eq("res_ovf", 64'(res_ovf), 64'(e.ovf));
                check_eq("res_trunc", 64'(res_trunc), 64'(e.trunc));
            end
        end
    end

    initial begin
        #200000;
        check_eq("watchdog", 64'(0), 64'(1));
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mac_clr", 64'(mac_clr), 64'(1));
        check_eq("rst_mac_a", 64'(mac_a), 64'(0));
        check_eq("rst_mac_b", 64'(mac_b), 64'(0));
        check_eq("rst_mac_cin", 64'(mac_cin), 64'(0));
        check_eq("rst_res_valid", 64'(res_valid), 64'(0));
        check_eq("rst_res_data", 64'(res_data), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: basic dot product and pop-to-result latency.
        push_pair(16'd3, 16'd4, 1'b0);
        push_pair(16'd5, 16'd6, 1'b1);
        g = 0;
        while (!(mac_a == 16'd5 && mac_b == 16'd6) && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("t1_latency", 64'(lat), 64'(2));
        wait_drain();

        // T2: accumulator wrap sets the sticky overflow flag.
        push_pair(16'hFFFF, 16'hFFFF, 1'b0);
        push_pair(16'hFFFF, 16'hFFFF, 1'b1);
        wait_drain();

        // T3: back-pressure on the result while the FIFO fills.
        res_ready = 1'b0;
        push_pair(16'd1, 16'd2, 1'b0);
        push_pair(16'd3, 16'd4, 1'b1);
        g = 0;
        while (!res_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_hold_valid", 64'(res_valid), 64'(1));
            check_eq("t3_hold_data", 64'(res_data), 64'(exp_q[0].data));
            check_eq("t3_hold_count", 64'(res_count), 64'(exp_q[0].cnt));
            if (i < 4) begin
                check_eq("t3_ready_open", 64'(in_ready), 64'(1));
                in_a = 16'(i + 1);
                in_b = 16'(i + 1);
                in_last = (i == 3);
                in_valid = 1'b1;
                @(posedge clk); #1;
                model_pair(16'(i + 1), 16'(i + 1), i == 3);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
                check_eq("t3_ready_full", 64'(in_ready), 64'(0));
                @(posedge clk); #1;
            end
        end
        res_ready = 1'b1;
        wait_drain();

        // T4: vector longer than MAX_LEN is split with the truncation flag.
        for (int i = 0; i < 6; i++) begin
            push_pair(16'd1, 16'd1, i == 5);
        end
        wait_drain();

        // T5: input gaps become bubbles that are neither summed nor counted.
        push_pair(16'd2, 16'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        push_pair(16'd4, 16'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        push_pair(16'd6, 16'd7, 1'b1);
        wait_drain();

        // T6: reset in the middle of a vector discards it.
        push_pair(16'd2, 16'd3, 1'b0);
        push_pair(16'd4, 16'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_sum = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        check_eq("t6_mac_clr", 64'(mac_clr), 64'(1));
        check_eq("t6_mac_a", 64'(mac_a), 64'(0));
        check_eq("t6_mac_b", 64'(mac_b), 64'(0));
        check_eq("t6_res_valid", 64'(res_valid), 64'(0));
        check_eq("t6_res_data", 64'(res_data), 64'(0));
        check_eq("t6_res_count", 64'(res_count), 64'(0));
        check_eq("t6_in_ready", 64'(in_ready), 64'(1));
        check_eq("t6_mac_acc", 64'(mac_acc), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("t6_clr_after_release", 64'(mac_clr), 64'(1));
        @(posedge clk); #1;
        check_eq("t6_clr_dropped", 64'(mac_clr), 64'(0));
        push_pair(16'd7, 16'd8, 1'b1);
        wait_drain();

        check_eq("result_total", 64'(n_results), 64'(8));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
